// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - register map, status bits and capture states for audio_capture
package audio_pkg;

   localparam logic [1:0] REG_CAP_ADDR   = 2'd0;
   localparam logic [1:0] REG_CAP_LENGTH = 2'd1;
   localparam logic [1:0] REG_CAP_COUNT  = 2'd2;
   localparam logic [1:0] REG_CAP_STATUS = 2'd3;

   localparam int STATUS_BUSY     = 0;
   localparam int STATUS_OVERFLOW = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_DRAIN
   } cap_state_t;

endpackage

// File: rtl/audio_capture_fifo.sv
// rtl/audio_capture_fifo.sv - synchronous word FIFO between the I2S deserialiser and the SDRAM writer
module audio_capture_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Extra pointer bit distinguishes full from empty; a pop frees the slot a full push needs.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - I2S ADC capture: deserialise stereo samples, buffer, write words to SDRAM
module audio_capture
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SAMPLE_BITS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        hwregs_request,
   input  logic        hwregs_write,
   input  logic [15:0] hwregs_addr,
   input  logic [31:0] hwregs_wdata,
   output logic [31:0] hwregs_rdata,
   input  logic        AUD_BCLK,
   input  logic        AUD_ADCLRCK,
   input  logic        AUD_ADCDAT,
   output logic        sdram_request,
   output logic        sdram_write,
   output logic [25:0] sdram_address,
   output logic [31:0] sdram_wdata,
   input  logic        sdram_ready
);
   localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SAMPLE_BITS - 1);
   localparam logic [CNT_W-1:0] BIT_DONE = CNT_W'(SAMPLE_BITS);

   logic [1:0]             bclk_sync, lrck_sync, dat_sync;
   logic                   bclk_prev, bclk_rise, lrck_s, dat_s;
   logic                   lrck_last, lrck_fall;
   logic [CNT_W-1:0]       bit_cnt;
   logic [SAMPLE_BITS-1:0] shift, shift_next, left;
   logic                   push;
   logic [31:0]            push_word;

   cap_state_t  state, next_state;
   logic [25:2] cap_addr, wptr;
   logic [31:0] cap_length, count, rd_mux, fifo_head;
   logic        overflow, accept, drop, pop, fifo_full, fifo_empty;
   logic        reg_wr, reg_rd, start;
   logic [1:0]  reg_sel;
   logic        unused_bits;

   assign unused_bits = ^{hwregs_addr[15:4], hwregs_addr[1:0]};

   // All three pins take the same two-flop path so their relative timing is preserved.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
         bclk_prev <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], AUD_BCLK};
         lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
         dat_sync  <= {dat_sync[0], AUD_ADCDAT};
         bclk_prev <= bclk_sync[1];
      end
   end

   assign bclk_rise  = bclk_sync[1] && !bclk_prev;
   assign lrck_s     = lrck_sync[1];
   assign dat_s      = dat_sync[1];
   assign lrck_fall  = bclk_rise && lrck_last && !lrck_s;
   assign shift_next = {shift[SAMPLE_BITS-2:0], dat_s};

   // The rise that reveals an LRCK change is the I2S delay bit, so it only restarts the count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lrck_last <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         left      <= '0;
         push      <= 1'b0;
         push_word <= '0;
      end else begin
         push <= 1'b0;
         if (bclk_rise) begin
            if (lrck_s != lrck_last) begin
               lrck_last <= lrck_s;
               bit_cnt   <= '0;
            end else if (bit_cnt != BIT_DONE) begin
               shift   <= shift_next;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  if (!lrck_last) begin
                     left <= shift_next;
                  end else begin
                     push      <= 1'b1;
                     push_word <= 32'({shift_next, left});
                  end
               end
            end
         end
      end
   end

   assign reg_wr  = hwregs_request && hwregs_write;
   assign reg_rd  = hwregs_request && !hwregs_write;
   assign reg_sel = hwregs_addr[3:2];
   assign start   = reg_wr && (reg_sel == REG_CAP_LENGTH) && (state == ST_IDLE)
                    && (hwregs_wdata != 32'd0);

   assign sdram_request = (state != ST_IDLE) && !fifo_empty;
   assign sdram_write   = sdram_request;
   assign sdram_address = {wptr, 2'b00};
   assign sdram_wdata   = sdram_request ? fifo_head : 32'd0;
   assign pop           = sdram_request && sdram_ready;

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      drop       = 1'b0;
      case (state)
         ST_IDLE:    if (start) next_state = ST_ARMED;
         ST_ARMED:   if (lrck_fall) next_state = ST_CAPTURE;
         ST_CAPTURE: begin
            if (push) begin
               if (!fifo_full || pop) begin
                  accept = 1'b1;
                  if (count == 32'd1) next_state = ST_DRAIN;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         ST_DRAIN:   if (fifo_empty) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 32'd0;
      case (reg_sel)
         REG_CAP_ADDR:   rd_mux = {6'd0, cap_addr, 2'b00};
         REG_CAP_LENGTH: rd_mux = cap_length;
         REG_CAP_COUNT:  rd_mux = count;
         REG_CAP_STATUS: begin
            rd_mux[STATUS_BUSY]     = (state != ST_IDLE);
            rd_mux[STATUS_OVERFLOW] = overflow;
         end
         default:        rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cap_addr     <= '0;
         cap_length   <= '0;
         count        <= '0;
         wptr         <= '0;
         overflow     <= 1'b0;
         hwregs_rdata <= '0;
      end else begin
         state <= next_state;
         if (reg_wr && reg_sel == REG_CAP_ADDR) cap_addr <= hwregs_wdata[25:2];
         if (reg_wr && reg_sel == REG_CAP_LENGTH && state == ST_IDLE)
            cap_length <= hwregs_wdata;
         if (start) begin
            count <= hwregs_wdata;
            wptr  <= cap_addr;
         end else if (accept) begin
            count <= count - 32'd1;
         end
         if (pop) wptr <= wptr + 1'b1;
         // A drop in the same cycle as a clear keeps the flag set so no overflow goes unseen.
         if (drop)
            overflow <= 1'b1;
         else if (reg_wr && reg_sel == REG_CAP_STATUS && hwregs_wdata[STATUS_OVERFLOW])
            overflow <= 1'b0;
         if (reg_rd) hwregs_rdata <= rd_mux;
      end
   end

   audio_capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept),
      .push_data (push_word),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_audio_capture.sv
// tb/tb_audio_capture.sv - self-checking bench for audio_capture
module tb_audio_capture;

   logic        clock = 1'b0;
   logic        reset;
   logic        hwregs_request, hwregs_write;
   logic [15:0] hwregs_addr;
   logic [31:0] hwregs_wdata, hwregs_rdata;
   logic        AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
   logic        sdram_request, sdram_write, sdram_ready;
   logic [25:0] sdram_address;
   logic [31:0] sdram_wdata;

   always #5 clock = ~clock;

   audio_capture #(.FIFO_DEPTH(8), .SAMPLE_BITS(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .hwregs_request (hwregs_request),
      .hwregs_write   (hwregs_write),
      .hwregs_addr    (hwregs_addr),
      .hwregs_wdata   (hwregs_wdata),
      .hwregs_rdata   (hwregs_rdata),
      .AUD_BCLK       (AUD_BCLK),
      .AUD_ADCLRCK    (AUD_ADCLRCK),
      .AUD_ADCDAT     (AUD_ADCDAT),
      .sdram_request  (sdram_request),
      .sdram_write    (sdram_write),
      .sdram_address  (sdram_address),
      .sdram_wdata    (sdram_wdata),
      .sdram_ready    (sdram_ready)
   );

   typedef struct {
      logic [15:0] left;
      logic [15:0] right;
      logic [31:0] word;
      logic [25:0] addr;
   } vec_t;

   int          n_vec = 0;
   int          n_bad = 0;
   int          rdy_mode = 1;
   logic [25:0] got_addr[$];
   logic [31:0] got_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] got_d(input int i);
      return (i < got_data.size()) ? got_data[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] got_a(input int i);
      return (i < got_addr.size()) ? {6'd0, got_addr[i]} : 32'hxxxx_xxxx;
   endfunction

   initial begin
      sdram_ready = 1'b0;
      forever begin
         @(negedge clock);
         case (rdy_mode)
            0:       sdram_ready = 1'b0;
            1:       sdram_ready = 1'b1;
            default: sdram_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (!reset && sdram_request && sdram_ready) begin
            got_addr.push_back(sdram_address);
            got_data.push_back(sdram_wdata);
            check("sdram_write", {31'd0, sdram_write}, 32'd1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running, expected finish");
      $fatal(1, "time limit");
   end

   task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clock);
      hwregs_request = 1'b1; hwregs_write = 1'b1; hwregs_addr = a; hwregs_wdata = d;
      @(negedge clock);
      hwregs_request = 1'b0; hwregs_write = 1'b0;
   endtask

   task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
      @(negedge clock);
      hwregs_request = 1'b1; hwregs_write = 1'b0; hwregs_addr = a;
      @(negedge clock);
      hwregs_request = 1'b0;
      d = hwregs_rdata;
   endtask

   task automatic slot(input logic lr, input logic d);
      @(negedge clock);
      AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; AUD_ADCDAT = d;
      repeat (4) @(negedge clock);
      AUD_BCLK = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   task automatic half(input logic lr, input logic [15:0] s);
      slot(lr, 1'($urandom));
      for (int i = 15; i >= 0; i--) slot(lr, s[i]);
      repeat (3) slot(lr, 1'($urandom));
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r);
      half(1'b0, l);
      half(1'b1, r);
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] st;
      int k;
      st = 32'd1;
      k = 0;
      while (st[0] && k < 400) begin
         reg_read(16'hC, st);
         k++;
      end
      check(name, {31'd0, st[0]}, 32'd0);
   endtask

   initial begin
      vec_t        basic[3];
      vec_t        wrapv[2];
      vec_t        alignv[2];
      logic [31:0] d;
      logic [15:0] bl[20], br[20];
      logic [31:0] exp_q[$];
      logic [25:0] exp_a[$];

      basic[0]  = '{16'h1234, 16'hABCD, 32'hABCD1234, 26'h0000100};
      basic[1]  = '{16'h0001, 16'h8000, 32'h80000001, 26'h0000104};
      basic[2]  = '{16'hFFFF, 16'h0000, 32'h0000FFFF, 26'h0000108};
      wrapv[0]  = '{16'h5A5A, 16'hC3C3, 32'hC3C35A5A, 26'h3FFFFFC};
      wrapv[1]  = '{16'h0F0F, 16'h7777, 32'h77770F0F, 26'h0000000};
      alignv[0] = '{16'h1111, 16'h2222, 32'h0,        26'h0};
      alignv[1] = '{16'h3333, 16'h4444, 32'h44443333, 26'h0000100};

      reset = 1'b1;
      hwregs_request = 1'b0; hwregs_write = 1'b0; hwregs_addr = '0; hwregs_wdata = '0;
      AUD_BCLK = 1'b1; AUD_ADCLRCK = 1'b1; AUD_ADCDAT = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_request", {31'd0, sdram_request}, 32'd0);
      check("reset_write",   {31'd0, sdram_write}, 32'd0);
      check("reset_address", {6'd0, sdram_address}, 32'd0);
      check("reset_wdata",   sdram_wdata, 32'd0);
      check("reset_rdata",   hwregs_rdata, 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         reg_read(16'(a * 4), d);
         check($sformatf("reset_reg%0d", a), d, 32'd0);
      end
      repeat (2) slot(1'b1, 1'b0);

      // basic capture from the table
      reg_write(16'h0, 32'h100);
      reg_read(16'h0, d);
      check("cap_addr_rd", d, 32'h100);
      reg_write(16'h4, 32'd3);
      reg_read(16'hC, d);
      check("busy_after_start", d, 32'h1);
      for (int i = 0; i < 3; i++) frame(basic[i].left, basic[i].right);
      wait_idle("basic_idle");
      check("basic_nwords", got_data.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("basic_data%0d", i), got_d(i), basic[i].word);
         check($sformatf("basic_addr%0d", i), got_a(i), {6'd0, basic[i].addr});
      end
      reg_read(16'h8, d);
      check("basic_count", d, 32'd0);

      // start in the middle of a right half: that frame must be discarded
      got_data.delete(); got_addr.delete();
      fork
         begin
            frame(alignv[0].left, alignv[0].right);
            frame(alignv[1].left, alignv[1].right);
         end
         begin
            repeat (220) @(negedge clock);
            reg_write(16'h4, 32'd1);
         end
      join
      wait_idle("align_idle");
      check("align_nwords", got_data.size(), 32'd1);
      check("align_data", got_d(0), alignv[1].word);
      check("align_addr", got_a(0), {6'd0, alignv[1].addr});

      // backpressure: only FIFO-depth words survive, the rest are dropped
      got_data.delete(); got_addr.delete();
      rdy_mode = 0;
      reg_write(16'h0, 32'h2000);
      reg_write(16'h4, 32'd12);
      for (int i = 0; i < 20; i++) begin
         bl[i] = 16'($urandom);
         br[i] = 16'($urandom);
         frame(bl[i], br[i]);
      end
      reg_read(16'hC, d);
      check("bp_status", d, 32'h3);
      reg_read(16'h8, d);
      check("bp_count", d, 32'd4);
      check("bp_no_writes", got_data.size(), 32'd0);
      rdy_mode = 1;
      repeat (50) @(negedge clock);
      check("bp_nwords", got_data.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_data%0d", i), got_d(i), {br[i], bl[i]});
         check($sformatf("bp_addr%0d", i), got_a(i), 32'h2000 + 32'(4 * i));
      end
      reg_read(16'hC, d);
      check("bp_still_busy", d, 32'h3);
      reg_write(16'hC, 32'h2);
      reg_read(16'hC, d);
      check("ovf_cleared", d, 32'h1);
      reg_write(16'h4, 32'd7);
      reg_read(16'h8, d);
      check("busy_len_count", d, 32'd4);
      reg_read(16'h4, d);
      check("busy_len_reg", d, 32'd12);
      got_data.delete(); got_addr.delete();
      for (int i = 0; i < 4; i++) begin
         bl[i] = 16'($urandom);
         br[i] = 16'($urandom);
         frame(bl[i], br[i]);
      end
      wait_idle("bp_idle");
      check("bp_tail_nwords", got_data.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_tail_data%0d", i), got_d(i), {br[i], bl[i]});
         check($sformatf("bp_tail_addr%0d", i), got_a(i), 32'h2020 + 32'(4 * i));
      end

      // zero length never arms
      got_data.delete(); got_addr.delete();
      reg_write(16'h4, 32'd0);
      reg_read(16'hC, d);
      check("zero_len_status", d, 32'd0);
      frame(16'hAAAA, 16'h5555);
      repeat (20) @(negedge clock);
      check("zero_len_writes", got_data.size(), 32'd0);
      reg_read(16'hC, d);
      check("zero_len_status2", d, 32'd0);

      // address low bits and wrap at 2^26
      reg_write(16'h0, 32'h0FFF_FFFF);
      reg_read(16'h0, d);
      check("addr_mask", d, 32'h03FF_FFFC);
      reg_write(16'h0, 32'h03FF_FFFC);
      reg_write(16'h4, 32'd2);
      for (int i = 0; i < 2; i++) frame(wrapv[i].left, wrapv[i].right);
      wait_idle("wrap_idle");
      check("wrap_nwords", got_data.size(), 32'd2);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("wrap_data%0d", i), got_d(i), wrapv[i].word);
         check($sformatf("wrap_addr%0d", i), got_a(i), {6'd0, wrapv[i].addr});
      end

      // random captures with random backpressure
      rdy_mode = 2;
      for (int it = 0; it < 4; it++) begin
         logic [25:0] base;
         int          len;
         logic [15:0] l, r;
         got_data.delete(); got_addr.delete();
         exp_q.delete(); exp_a.delete();
         base = 26'($urandom) & 26'h3FF_FFFC;
         len  = $urandom_range(1, 4);
         reg_write(16'h0, {6'd0, base});
         reg_write(16'h4, 32'(len));
         for (int i = 0; i < len; i++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            exp_q.push_back({r, l});
            exp_a.push_back(26'((32'(base) + 32'(4 * i)) % 32'h0400_0000));
            frame(l, r);
         end
         wait_idle($sformatf("rand%0d_idle", it));
         check($sformatf("rand%0d_nwords", it), got_data.size(), 32'(len));
         for (int i = 0; i < len; i++) begin
            check($sformatf("rand%0d_data%0d", it, i), got_d(i), exp_q[i]);
            check($sformatf("rand%0d_addr%0d", it, i), got_a(i), {6'd0, exp_a[i]});
         end
      end

      // reset during drain with a request outstanding
      rdy_mode = 0;
      got_data.delete(); got_addr.delete();
      reg_write(16'h0, 32'h40);
      reg_write(16'h4, 32'd1);
      frame(16'h1357, 16'h2468);
      repeat (5) @(negedge clock);
      check("drain_req_pending", {31'd0, sdram_request}, 32'd1);
      check("drain_addr", {6'd0, sdram_address}, 32'h40);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst_req_now", {31'd0, sdram_request}, 32'd0);
      check("rst_addr_now", {6'd0, sdram_address}, 32'd0);
      check("rst_wdata_now", sdram_wdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      rdy_mode = 1;
      for (int a = 0; a < 4; a++) begin
         reg_read(16'(a * 4), d);
         check($sformatf("post_rst_reg%0d", a), d, 32'd0);
      end
      repeat (20) @(negedge clock);
      check("post_rst_writes", got_data.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_capture.md
Name: audio_capture

Overview:
- I2S receiver for the codec ADC path.
- Deserialises 16-bit stereo samples from AUD_ADCDAT, packs each left/right pair into one 32-bit word, buffers the words in a small FIFO, and writes them to SDRAM as single-word writes.
- Started and monitored through four hwregs registers.
- Shares BCLK/LRCLK timing with the playback engine; it is the capture counterpart of the DAC output path.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit words buffered between I2S and SDRAM (power of 2).
- SAMPLE_BITS, 16, bits captured per channel, MSB first.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hwregs_request  in  1  register access strobe.
- hwregs_write  in  1  1 = write, 0 = read.
- hwregs_addr  in  16  byte address; only [3:2] decoded.
- hwregs_wdata  in  32  write data.
- hwregs_rdata  out  32  read data, registered.
- AUD_BCLK  in  1  bit clock from the audio clock generator.
- AUD_ADCLRCK  in  1  ADC LR clock; low = left, high = right.
- AUD_ADCDAT  in  1  serial ADC data from the codec.
- sdram_request  out  1  write request.
- sdram_write  out  1  always 1 while sdram_request is high.
- sdram_address  out  26  byte address of the write.
- sdram_wdata  out  32  {right[15:0], left[15:0]}.
- sdram_ready  in  1  request accepted in any cycle where sdram_request && sdram_ready.

Behaviour:
- Registers:
  - 0x0 CAP_ADDR (RW): start byte address; bits [1:0] read as 0.
  - 0x4 CAP_LENGTH (RW): stereo words to capture. A write while idle starts capture; a write while busy is ignored.
  - 0x8 CAP_COUNT (RO): words still to be pushed into the FIFO.
  - 0xC CAP_STATUS: bit0 busy (RO); bit1 overflow (sticky, write 1 to clear).
- hwregs_rdata is updated on the cycle after a read request. Unmapped bits read as 0.
- Input sync: AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT each pass through two flops, giving equal delay. The BCLK rising-edge event is detected as sync==1 && prev==0.
- Deserialiser:
  - A change of LRCK, seen at a BCLK rise, resets the bit counter.
  - The first BCLK rise after an LRCK change is the I2S delay bit and is ignored.
  - The next SAMPLE_BITS rises shift data in MSB-first; further bits in the half-frame are ignored.
  - A completed left half latches into the left holding register.
  - A completed right half forms the word {right, left} and raises a one-cycle push.
- State machine:
  - IDLE: busy=0. A CAP_LENGTH write with a nonzero value latches the length into count and CAP_ADDR into the write pointer, then goes to ARMED. A zero length stays in IDLE.
  - ARMED: discard data until an LRCK falling edge (start of a left half), then go to CAPTURE. This keeps every word channel-aligned.
  - CAPTURE: on each push, if the FIFO is not full, enqueue the word and decrement count. If the FIFO is full, drop the word, set overflow, and leave count unchanged. When count reaches 0, go to DRAIN.
  - DRAIN: go to IDLE when the FIFO is empty and no request is outstanding.
- busy=1 in ARMED, CAPTURE and DRAIN.
- SDRAM side:
  - sdram_request=1 whenever the FIFO is non-empty, in any non-IDLE state; wdata = FIFO head, address = write pointer.
  - On handshake: pop, and add 4 to the write pointer. The pointer wraps modulo 2^26.
  - request/address/wdata stay stable until accepted.
- FIFO: a simultaneous push and pop when full is allowed, with no overflow.
- Reset values: hwregs_rdata=0, sdram_request=0, sdram_write=0, sdram_address=0, sdram_wdata=0; all registers 0; FIFO empty; state IDLE. Reset mid-transfer abandons the transfer immediately.

Decomposition:
- Package audio_pkg: register offsets (CAP_ADDR, CAP_LENGTH, CAP_COUNT, CAP_STATUS), capture state enum, status bit positions.
- One sub-module: audio_capture_fifo (synchronous, FIFO_DEPTH x 32, full/empty flags, push/pop, simultaneous push+pop).

Test Plan:
- Capture basic: CAP_ADDR=0x100, CAP_LENGTH=3; drive left=0x1234/right=0xABCD, then 0x0001/0x8000, then 0xFFFF/0x0000 -> writes 0xABCD1234 @0x100, 0x80000001 @0x104, 0x0000FFFF @0x108; busy falls; CAP_COUNT=0.
- Alignment: start CAP_LENGTH=1 mid-right-half -> partial frame discarded; first word written comes from the next complete left/right pair.
- Backpressure: sdram_ready=0 for 20 frames, CAP_LENGTH=12 -> 8 words are held, later frames are dropped, overflow=1. After ready rises, 8 sequential writes; count ends at 4 and busy stays 1.
- Overflow clear and ignore: write 0x2 to CAP_STATUS -> overflow=0. A CAP_LENGTH write while busy -> count unchanged.
- Edge cases: CAP_LENGTH=0 -> busy never set, no requests. CAP_ADDR=0x3FFFFFC, CAP_LENGTH=2 -> second write to address 0x0000000.
- Reset: assert reset during DRAIN with a request pending -> sdram_request=0 in the same cycle; state IDLE; all registers read 0.
